// File: rtl/alu_div_pkg.sv
// Shared types and defaults for the sequential divider.
// The signed option is enabled by defining ALU_DIV_SIGNED_EN.
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEF = 8;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor if it fits.
module alu_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // The extra top bit is the borrow; it is clear when the trial is non-negative.
  assign trial            = {1'b0, rem, quo_msb} - {2'b00, dvs};
  assign q_bit            = ~trial[WIDTH+1];
  assign rem_next         = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo_msb};
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Define ALU_DIV_SIGNED_EN to add the signed_mode port (two's complement operands).
module alu_seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only on an edge where state==IDLE (busy==0);
  // operands are sampled on that edge, and done pulses for one cycle once
  // quotient/remainder/div_by_zero are valid.
  div_state_t       state;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo_msb  (quo_r[WIDTH-1]),
    .dvs      (dvs_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_final = {quo_r[WIDTH-2:0], q_bit};

`ifdef ALU_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (signed_mode && dividend[WIDTH-1]) dvd_mag = -dividend;
    if (signed_mode && divisor[WIDTH-1])  dvs_mag = -divisor;
  end

  // Sign fixup on the final step so the signed latency matches unsigned.
  assign q_out = neg_q ? -quo_final : quo_final;
  assign r_out = neg_r ? -rem_next  : rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= signed_mode && dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_out   = quo_final;
  assign r_out   = rem_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              rem_r <= '0;
              quo_r <= dvd_mag;
              dvs_r <= dvs_mag;
              count <= '0;
            end
          end
        end
        RUN: begin
          rem_r <= rem_next;
          quo_r <= quo_final;
          count <= count + 1'b1;
          if (count == LAST) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= q_out;
            remainder   <= r_out;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed and random checks of alu_seq_divider against an arithmetic reference.
// Signed cases are compiled in when ALU_DIV_SIGNED_EN is defined.
module tb_alu_seq_divider;
  import alu_div_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int compared   = 0;
  int mismatched = 0;
  logic [2*W:0] exp_q[$];

  alu_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef ALU_DIV_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain division from the spec's arithmetic rules.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sm);
    logic [W-1:0] q;
    logic [W-1:0] r;
    int sa, sb, qi, ri;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Issue one op, wait for done, check latency/busy/results/pulse width.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm);
    int n;
    int busy_cnt;
    logic [2*W:0] e;
    exp_q.push_back(model(a, b, sm));
    start = 1'b1; dividend = a; divisor = b; signed_mode = sm;
    tick();
    start = 1'b0;
    n = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (busy === 1'b1) busy_cnt++;
    end
    check({tag, "_latency"}, n, (b == 0) ? 0 : W);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 1 : W + 1);
    e = exp_q.pop_front();
    check({tag, "_quotient"}, quotient, e[2*W-1:W]);
    check({tag, "_remainder"}, remainder, e[W-1:0]);
    check({tag, "_dbz"}, div_by_zero, e[2*W]);
    if (!sm && b != 0) begin
      check({tag, "_identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, "_rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_clear"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; signed_mode = 1'b0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_state", dut.state, IDLE);
    @(negedge clk); rst = 1'b0;
    tick();

    // Basic cases
    run_div("d100_7", 8'd100, 8'd7, 1'b0);
    check("d100_7_q", quotient, 14);
    check("d100_7_r", remainder, 2);
    run_div("d255_1", 8'd255, 8'd1, 1'b0);
    run_div("d5_9", 8'd5, 8'd9, 1'b0);
    run_div("d0_3", 8'd0, 8'd3, 1'b0);
    run_div("d42_0", 8'd42, 8'd0, 1'b0);
    check("d42_0_q", quotient, 8'hFF);
    check("d42_0_r", remainder, 8'd42);
    check("d42_0_state", dut.state, IDLE);

    // start hammered during a run: only one result, then accept right after
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    tick();
    n = 0; pulses = 0;
    while (done !== 1'b1 && n < 40) begin
      dividend = 8'($urandom_range(0, 255));
      divisor  = 8'($urandom_range(1, 255));
      tick();
      n++;
    end
    check("hammer_latency", n, W);
    check("hammer_q", quotient, 15);
    check("hammer_r", remainder, 5);
    dividend = 8'd100; divisor = 8'd7;
    tick();
    check("hammer_ignored_in_done", busy, 1'b0);
    check("hammer_hold_q", quotient, 15);
    tick();
    check("b2b_accept_busy", busy, 1'b1);
    check("b2b_accept_cleared_q", quotient, 0);
    check("b2b_state", dut.state, RUN);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("b2b_q", quotient, 14);
    check("b2b_r", remainder, 2);
    tick();

    // Asynchronous abort mid-run
    start = 1'b1; dividend = 8'd99; divisor = 8'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_state", dut.state, IDLE);
    @(negedge clk); rst = 1'b0;
    tick();
    run_div("d99_4", 8'd99, 8'd4, 1'b0);
    check("d99_4_q", quotient, 24);
    check("d99_4_r", remainder, 3);

`ifdef ALU_DIV_SIGNED_EN
    run_div("s_m7_2", 8'hF9, 8'h02, 1'b1);
    check("s_m7_2_q", quotient, 8'hFD);
    check("s_m7_2_r", remainder, 8'hFF);
    run_div("s_m128_m1", 8'h80, 8'hFF, 1'b1);
    check("s_m128_m1_q", quotient, 8'h80);
    run_div("s_7_m2", 8'h07, 8'hFE, 1'b1);
    check("s_7_m2_r", remainder, 8'h01);
    run_div("s_m5_0", 8'hFB, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_div("s_rand", a, b, 1'b1);
    end
`endif

    // Random unsigned
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 10 == 9) ? 8'd0 : 8'($urandom_range(1, 255));
      run_div("u_rand", a, b, 1'b0);
    end

    // Idle with no start: nothing should happen
    repeat (3) tick();
    check("idle_no_done", done, 1'b0);
    check("idle_no_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
